// File: rtl/adc_clip_monitor_pkg.sv
// Shared types and helpers for the ADC clip monitor.
// Holds FSM state enums, channel-index width and the full-scale detector.
package adc_clip_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    ACQ
  } ctrl_state_t;

  typedef enum logic {
    D_IDLE,
    D_SEND
  } dump_state_t;

  localparam int N_CH_DEF = 4;
  localparam int CH_W = (N_CH_DEF > 1) ? $clog2(N_CH_DEF) : 1;
  localparam int MAX_DIN = 32;

  // Left-justify the sample so both full-scale codes become fixed
  // patterns in the top din_width bits of a MAX_DIN-wide word.
  function automatic logic is_fullscale(
    input logic [MAX_DIN-1:0] s,
    input int                 din_width
  );
    logic [MAX_DIN-1:0] t;
    logic [MAX_DIN-1:0] neg;
    logic [MAX_DIN-1:0] pos;
    t   = s << (MAX_DIN - din_width);
    neg = {1'b1, {(MAX_DIN-1){1'b0}}};
    pos = neg - (MAX_DIN'(1) << (MAX_DIN - din_width));
    return (t == neg) || (t == pos);
  endfunction

endpackage

// File: rtl/adc_clip_monitor_if.sv
// Result stream of the clip monitor: one clip count per channel.
// master drives data/ch/valid/last, slave returns ready.
interface adc_clip_monitor_if
  import adc_clip_monitor_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int CH_WIDTH  = CH_W
) ();

  logic [CNT_WIDTH-1:0] m_data;
  logic [CH_WIDTH-1:0]  m_ch;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (
    output m_data,
    output m_ch,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_ch,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/adc_clip_monitor_clip_lane.sv
// One channel: registered clip detector, saturating window counter,
// shadow copy at window end and sticky threshold flag.
module clip_lane
  import adc_clip_monitor_pkg::*;
#(
  parameter int DIN_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 accept,
  input  logic                 run,
  input  logic                 win_end,
  input  logic                 commit,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] thresh,
  output logic [CNT_WIDTH-1:0] shadow,
  output logic                 flag
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 det_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 set;

  // det_q still carries the last sample of the window when win_end
  // is seen, so cnt_nxt is the complete window count.
  always_comb begin
    cnt_nxt = cnt_q;
    if (det_q && (cnt_q != CNT_MAX))
      cnt_nxt = cnt_q + 1'b1;
  end

  assign set = commit && (thresh != '0)
             && (cnt_nxt >= thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q  <= 1'b0;
      cnt_q  <= '0;
      shadow <= '0;
      flag   <= 1'b0;
    end else begin
      det_q <= accept
             && is_fullscale(MAX_DIN'(din), DIN_WIDTH);
      if (win_end || !run)
        cnt_q <= '0;
      else
        cnt_q <= cnt_nxt;
      if (commit)
        shadow <= cnt_nxt;
      if (set)
        flag <= 1'b1;
      else if (clear)
        flag <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_clip_monitor.sv
// Windowed clip monitor: control/dump FSMs, window counter, output mux.
// Ports: din/valid in, win_len/thresh/start/stop/sync/clear, m stream out.
module adc_clip_monitor
  import adc_clip_monitor_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int DIN_WIDTH = 8,
  parameter int WIN_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH*DIN_WIDTH-1:0] din,
  input  logic                      din_valid,
  input  logic [WIN_WIDTH-1:0]      win_len,
  input  logic [CNT_WIDTH-1:0]      thresh,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      sync_in,
  input  logic                      clear,
  adc_clip_monitor_if.master        m,
  output logic [N_CH-1:0]           clip_flags,
  output logic                      overrun,
  output logic                      busy
);

  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  ctrl_state_t          cst;
  dump_state_t          dst;
  logic [WIN_WIDTH-1:0] len_q;
  logic [WIN_WIDTH-1:0] idx_q;
  logic [CNT_WIDTH-1:0] thr_q;
  logic [CHW-1:0]       ch_q;
  logic                 end_q;
  logic                 accept;
  logic                 last_smp;
  logic                 run;
  logic                 drop;
  logic                 commit;
  logic [CNT_WIDTH-1:0] shadow [N_CH];

  // The sync cycle's sample is sample 0; stop suppresses the sample.
  assign accept = din_valid && !stop
                && ((cst == ACQ)
                 || ((cst == WAIT_SYNC) && sync_in));
  assign last_smp = accept && (idx_q == len_q - 1'b1);
  assign run      = (cst == ACQ);
  // A result arriving while a dump is still streaming is discarded.
  assign drop     = end_q && (dst == D_SEND);
  assign commit   = end_q && !drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst   <= IDLE;
      len_q <= WIN_WIDTH'(1);
      thr_q <= '0;
      idx_q <= '0;
      end_q <= 1'b0;
      busy  <= 1'b0;
    end else begin
      end_q <= last_smp;
      if (accept)
        idx_q <= last_smp ? '0 : idx_q + 1'b1;
      else if (stop || (cst != ACQ))
        idx_q <= '0;
      if (stop) begin
        cst  <= IDLE;
        busy <= 1'b0;
      end else begin
        unique case (cst)
          IDLE: begin
            if (start) begin
              cst   <= WAIT_SYNC;
              busy  <= 1'b1;
              thr_q <= thresh;
              len_q <= (win_len == '0)
                     ? WIN_WIDTH'(1) : win_len;
            end
          end
          WAIT_SYNC: begin
            if (sync_in)
              cst <= ACQ;
          end
          ACQ: begin
            cst <= ACQ;
          end
          default: begin
            cst  <= IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst       <= D_IDLE;
      ch_q      <= '0;
      m.m_valid <= 1'b0;
      m.m_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      unique case (dst)
        D_IDLE: begin
          if (commit) begin
            dst       <= D_SEND;
            ch_q      <= '0;
            m.m_valid <= 1'b1;
            m.m_last  <= (N_CH == 1);
          end
        end
        D_SEND: begin
          if (m.m_ready) begin
            if (m.m_last) begin
              dst       <= D_IDLE;
              ch_q      <= '0;
              m.m_valid <= 1'b0;
              m.m_last  <= 1'b0;
            end else begin
              ch_q     <= ch_q + 1'b1;
              m.m_last <= (ch_q == CHW'(N_CH - 2));
            end
          end
        end
        default: begin
          dst       <= D_IDLE;
          m.m_valid <= 1'b0;
          m.m_last  <= 1'b0;
        end
      endcase
      if (drop)
        overrun <= 1'b1;
      else if (clear)
        overrun <= 1'b0;
    end
  end

  // Shadow is frozen during D_SEND, so the mux output holds steady
  // under backpressure.
  assign m.m_ch   = ch_q;
  assign m.m_data = shadow[ch_q];

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    clip_lane #(
      .DIN_WIDTH (DIN_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din[i*DIN_WIDTH +: DIN_WIDTH]),
      .accept  (accept),
      .run     (run),
      .win_end (end_q),
      .commit  (commit),
      .clear   (clear),
      .thresh  (thr_q),
      .shadow  (shadow[i]),
      .flag    (clip_flags[i])
    );
  end

endmodule
